// File: rtl/inst_fetch_buffer_pkg.sv
// Shared types for the instruction fetch buffer: the 97-bit queue entry,
// its field offsets and the entry builder used on the write side.
package fetch_pkg;

    localparam int ENTRY_W    = 97;
    localparam int TARGET_LSB = 0;
    localparam int TAKEN_BIT  = 32;
    localparam int PC_LSB     = 33;
    localparam int INST_LSB   = 65;

    localparam logic [31:0] RESET_PC = 32'h1C00_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } fetch_entry_t;

    // A not-taken entry always carries a zero target.
    function automatic fetch_entry_t make_entry(input logic [31:0] inst,
                                                input logic [31:0] pc,
                                                input logic        taken,
                                                input logic [31:0] target);
        fetch_entry_t e;
        e.inst   = inst;
        e.pc     = pc;
        e.taken  = taken;
        e.target = taken ? target : 32'h0000_0000;
        return e;
    endfunction

endpackage

// File: rtl/inst_fetch_buffer_if.sv
// Fetch-side and decode-side signals of the instruction fetch buffer.
interface inst_fetch_buffer_if #(
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic             inst_valid;
    logic             pc_suspend;
    logic [31:0]      inst_in1;
    logic [31:0]      inst_in2;
    logic [31:0]      pc_in1;
    logic [31:0]      pc_in2;
    logic [31:0]      pred_addr_in;
    logic             pred_taken1_in;
    logic             pred_taken2_in;
    logic             buf_full;
    logic             dec_ready;
    logic             out_valid1;
    logic             out_valid2;
    logic [31:0]      out_inst1;
    logic [31:0]      out_inst2;
    logic [31:0]      out_pc1;
    logic [31:0]      out_pc2;
    logic             out_taken1;
    logic             out_taken2;
    logic [31:0]      out_target1;
    logic [31:0]      out_target2;
    logic [CNT_W-1:0] count;

    modport master (
        output flush, inst_valid, pc_suspend, inst_in1, inst_in2, pc_in1, pc_in2,
               pred_addr_in, pred_taken1_in, pred_taken2_in, dec_ready,
        input  buf_full, out_valid1, out_valid2, out_inst1, out_inst2, out_pc1, out_pc2,
               out_taken1, out_taken2, out_target1, out_target2, count
    );

    modport slave (
        input  flush, inst_valid, pc_suspend, inst_in1, inst_in2, pc_in1, pc_in2,
               pred_addr_in, pred_taken1_in, pred_taken2_in, dec_ready,
        output buf_full, out_valid1, out_valid2, out_inst1, out_inst2, out_pc1, out_pc2,
               out_taken1, out_taken2, out_target1, out_target2, count
    );

endinterface

// File: rtl/inst_fetch_buffer_chk.sv
// Occupancy invariant for the instruction fetch buffer. An underflow wraps
// the unsigned count above DEPTH, so one bound covers both directions.
module inst_fetch_buffer_chk #(
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input logic             clk,
    input logic             rst,
    input logic [CNT_W-1:0] count
);

    a_count_bound: assert property (@(posedge clk) disable iff (!rst) count <= CNT_W'(DEPTH))
        else $error("count out of range: %0d", count);

endmodule

// File: rtl/inst_fetch_buffer_entry_array.sv
// Entry storage: DEPTH x ENTRY_W registers, two write ports and two
// asynchronous read ports. Write addresses are always distinct.
module ifb_entry_array
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we1,
    input  logic             we2,
    input  logic [PTR_W-1:0] wr_addr1,
    input  logic [PTR_W-1:0] wr_addr2,
    input  fetch_entry_t     wr_data1,
    input  fetch_entry_t     wr_data2,
    input  logic [PTR_W-1:0] rd_addr1,
    input  logic [PTR_W-1:0] rd_addr2,
    output fetch_entry_t     rd_data1,
    output fetch_entry_t     rd_data2
);

    fetch_entry_t mem_r [DEPTH];

    // Storage write; port 1 wins should both ports ever name the same slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we1 && (wr_addr1 == PTR_W'(i))) begin
                    mem_r[i] <= wr_data1;
                end else if (we2 && (wr_addr2 == PTR_W'(i))) begin
                    mem_r[i] <= wr_data2;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

    assign rd_data1 = mem_r[rd_addr1];
    assign rd_data2 = mem_r[rd_addr2];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Dual-issue instruction queue between the I-cache and decode: pointer,
// occupancy and flush control around the two-port entry array.
module inst_fetch_buffer
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input logic                clk,
    input logic                rst,
    inst_fetch_buffer_if.slave bus
);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             push_s;
    logic             we2_s;
    logic [1:0]       push_cnt_s;
    logic [1:0]       pop_cnt_s;
    logic             valid1_s;
    logic             valid2_s;
    fetch_entry_t     wr_data1_s;
    fetch_entry_t     wr_data2_s;
    fetch_entry_t     rd_data1_s;
    fetch_entry_t     rd_data2_s;

    assign full_s   = count_r > CNT_W'(DEPTH - 2);
    assign valid1_s = count_r >= CNT_W'(1);
    assign valid2_s = count_r >= CNT_W'(2);

    // Push/pop decisions; a taken first slot truncates the group to one entry.
    always_comb begin
        push_s     = bus.inst_valid & ~bus.pc_suspend & ~full_s & ~bus.flush;
        we2_s      = push_s & ~bus.pred_taken1_in;
        wr_data1_s = make_entry(bus.inst_in1, bus.pc_in1, bus.pred_taken1_in, bus.pred_addr_in);
        wr_data2_s = make_entry(bus.inst_in2, bus.pc_in2, bus.pred_taken2_in, bus.pred_addr_in);
        push_cnt_s = 2'd0;
        pop_cnt_s  = 2'd0;
        if (push_s) begin
            push_cnt_s = bus.pred_taken1_in ? 2'd1 : 2'd2;
        end else begin
            push_cnt_s = 2'd0;
        end
        if (!bus.dec_ready || bus.flush) begin
            pop_cnt_s = 2'd0;
        end else if (valid2_s) begin
            pop_cnt_s = 2'd2;
        end else if (valid1_s) begin
            pop_cnt_s = 2'd1;
        end else begin
            pop_cnt_s = 2'd0;
        end
    end

    // Pointers and occupancy; flush clears everything ahead of push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (bus.flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(push_cnt_s);
            rd_ptr_r <= rd_ptr_r + PTR_W'(pop_cnt_s);
            count_r  <= count_r + CNT_W'(push_cnt_s) - CNT_W'(pop_cnt_s);
        end
    end

    ifb_entry_array #(.DEPTH(DEPTH)) u_array (
        .clk      (clk),
        .rst      (rst),
        .we1      (push_s),
        .we2      (we2_s),
        .wr_addr1 (wr_ptr_r),
        .wr_addr2 (wr_ptr_r + PTR_W'(1)),
        .wr_data1 (wr_data1_s),
        .wr_data2 (wr_data2_s),
        .rd_addr1 (rd_ptr_r),
        .rd_addr2 (rd_ptr_r + PTR_W'(1)),
        .rd_data1 (rd_data1_s),
        .rd_data2 (rd_data2_s)
    );

    // Decode-side view of the two oldest entries, zeroed when not valid.
    always_comb begin
        bus.buf_full    = full_s;
        bus.count       = count_r;
        bus.out_valid1  = valid1_s;
        bus.out_valid2  = valid2_s;
        bus.out_inst1   = 32'h0000_0000;
        bus.out_pc1     = 32'h0000_0000;
        bus.out_taken1  = 1'b0;
        bus.out_target1 = 32'h0000_0000;
        bus.out_inst2   = 32'h0000_0000;
        bus.out_pc2     = 32'h0000_0000;
        bus.out_taken2  = 1'b0;
        bus.out_target2 = 32'h0000_0000;
        if (valid1_s) begin
            bus.out_inst1   = rd_data1_s.inst;
            bus.out_pc1     = rd_data1_s.pc;
            bus.out_taken1  = rd_data1_s.taken;
            bus.out_target1 = rd_data1_s.target;
        end else begin
            bus.out_taken1  = 1'b0;
        end
        if (valid2_s) begin
            bus.out_inst2   = rd_data2_s.inst;
            bus.out_pc2     = rd_data2_s.pc;
            bus.out_taken2  = rd_data2_s.taken;
            bus.out_target2 = rd_data2_s.target;
        end else begin
            bus.out_taken2  = 1'b0;
        end
    end

endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
- Dual-issue instruction queue directly downstream of the instruction cache.
- Accepts up to two fetched instructions per cycle, with PCs and branch-prediction info, and truncates the fetch group after a predicted-taken first slot.
- Presents up to two oldest entries per cycle to decode; back-pressures fetch via buf_full and clears on pipeline flush.

Parameters:
- DEPTH, 16: number of entries; power of two, ≥4.
- PTR_W, $clog2(DEPTH): pointer width; count is PTR_W+1 bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  mispredict/exception flush, synchronous
- inst_valid  in  1  fetch group valid (both slots hit)
- pc_suspend  in  1  cache refill in progress; push suppressed
- inst_in1  in  32  instruction, slot 1
- inst_in2  in  32  instruction, slot 2
- pc_in1  in  32  PC, slot 1
- pc_in2  in  32  PC, slot 2
- pred_addr_in  in  32  predicted target of the group
- pred_taken1_in  in  1  slot 1 predicted taken
- pred_taken2_in  in  1  slot 2 predicted taken
- buf_full  out  1  fewer than 2 free entries; fetch must hold
- dec_ready  in  1  decode consumes the presented entries
- out_valid1  out  1  entry at head valid
- out_valid2  out  1  entry at head+1 valid
- out_inst1 / out_inst2  out  32  instructions
- out_pc1 / out_pc2  out  32  PCs
- out_taken1 / out_taken2  out  1  predicted-taken flags
- out_target1 / out_target2  out  32  predicted targets (0 when not taken)
- count  out  PTR_W+1  occupancy (debug/perf)

Behaviour:
- Entry format: {inst[31:0], pc[31:0], taken, target[31:0]}, 97 bits.
- Reset (rst=0, async):
  - wr_ptr=0, rd_ptr=0, count=0.
  - All outputs 0; buf_full=0.
  - Storage contents are don't-care.
- buf_full = (count > DEPTH-2). Combinational from registered count.
- push = inst_valid & !pc_suspend & !buf_full & !flush.
  - If pred_taken1_in=1: write one entry at wr_ptr with taken=1, target=pred_addr_in; slot 2 is discarded; wr_ptr += 1.
  - Otherwise: write slot 1 at wr_ptr (taken=0, target=0) and slot 2 at wr_ptr+1 (taken=pred_taken2_in, target=pred_taken2_in ? pred_addr_in : 0); wr_ptr += 2.
  - A push attempted while buf_full=1 is dropped. Fetch is responsible for holding.
- pop = dec_ready & !flush.
  - Pop count is min(count, 2). Reads are first-word-fall-through.
  - out_valid1 = (count ≥ 1); out_valid2 = (count ≥ 2).
  - Data outputs are masked to 0 when the corresponding valid is 0.
  - dec_ready with count=0 is a no-op; with count=1, rd_ptr advances by 1.
- Simultaneous push and pop are legal: count_next = count + pushed − popped. buf_full uses the pre-update count.
- Latency: an entry pushed at edge N is visible on the outputs after edge N (1 cycle). No empty-bypass path.
- Pointer wrap: pointers wrap modulo DEPTH. A two-entry write that straddles DEPTH-1→0 is legal. FIFO order is preserved.
- Flush takes priority over push and pop. On the next edge: wr_ptr=rd_ptr=0, count=0, all valids 0.
- Reset mid-operation discards all contents immediately (asynchronous).
- Invariant (assertion): count never exceeds DEPTH and never underflows.

Decomposition:
- Shared package (fetch_pkg):
  - ENTRY_W=97 and field offset constants.
  - fetch_entry_t struct {inst, pc, taken, target}.
  - Reset PC constant for the bench.
- One sub-module: ifb_entry_array, a DEPTH×ENTRY_W register array with 2 write ports (wr_ptr, wr_ptr+1) and 2 async read ports (rd_ptr, rd_ptr+1).
- Pointer, count and flush logic stay in the top level.

Test Plan:
- Reset: rst=0 mid-traffic → next sample shows count=0, out_valid1/2=0, all outputs 0, buf_full=0.
- Basic push: inst_valid=1, pc_in1=0x1C000000, pc_in2=0x1C000004, no taken, dec_ready=0 → after 1 edge: count=2, out_pc1=0x1C000000, out_pc2=0x1C000004, out_taken1/2=0.
- Taken truncation: pred_taken1_in=1, pred_addr_in=0x1C000100 → count += 1, out_taken1=1, out_target1=0x1C000100, slot 2 not stored.
- Full: fill to count=15 (DEPTH=16) → buf_full=1. Further push with dec_ready=0 leaves count at 15. Pop 2 plus push-attempt in the same cycle → count=13, then push accepted the next cycle.
- Flush priority: count=6, push and dec_ready asserted with flush=1 → next edge count=0, out_valid1=0.
- Wrap/order: stream 48 sequential PCs (step 4) under random dec_ready and random pred_taken2 → decode receives PCs in strict order with matching taken/target flags; buf_full never overflows.
